pong_game_ctrl: RTL

- Match sequencer for the Pong datapath. Decides when the ball/paddle logic in pixel_gen may move, when the ball is re-centred and which way it serves.
- Keeps both player scores and detects the winner.
- Sits beside pixel_gen in the top level, clocked by the 100 MHz system clock. Consumes the per-frame refresh tick, the ball-miss strobes from pixel_gen, and the debounced start button.

---
 rtl/pong_pkg.sv | 23 ++
 rtl/pong_game_ctrl_frame_timer.sv | 34 +++
 rtl/pong_game_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the Pong match controller, pixel generator and score overlay.
package pong_pkg;

  // Match sequencer state encodings, also shown on the debug overlay
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  // Side constants used for serve direction and winner
  localparam logic P1 = 1'b0;
  localparam logic P2 = 1'b1;

  // Default match timing and scoring
  localparam int DEF_WIN_SCORE    = 7;
  localparam int DEF_SERVE_FRAMES = 60;
  localparam int DEF_POINT_FRAMES = 90;
  localparam int DEF_TMR_W        = 7;

endpackage

// File: rtl/pong_game_ctrl_frame_timer.sv
// Counts frame ticks and pulses done on the tick that reaches LIMIT-1.
module frame_timer #(
  parameter int LIMIT = 60,
  parameter int W     = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic tick,
  output logic done
);

  logic [W-1:0] count;
  logic         at_last;

  assign at_last = (count == W'(LIMIT - 1));
  assign done    = tick & at_last & ~clr;

  // Frame counter: held at zero while cleared, wraps to zero on completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (tick) begin
      if (at_last) begin
        count <= '0;
      end else begin
        count <= count + W'(1);
      end
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Match sequencer: serve hold, play, point freeze, scoring and winner detection.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = DEF_WIN_SCORE,
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int POINT_FRAMES = DEF_POINT_FRAMES,
  parameter int TMR_W        = DEF_TMR_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refr_tick,
  input  logic       start,
  input  logic       miss1,
  input  logic       miss2,
  output logic       ball_rst,
  output logic       move_en,
  output logic       serve_dir,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state
);

  state_t cur_state;
  logic   start_q;
  logic   start_pulse;
  logic   serve_done;
  logic   point_done;
  logic   in_serve;
  logic   in_point;
  logic   win_reached;

  assign start_pulse = start & ~start_q;
  assign in_serve    = (cur_state == ST_SERVE);
  assign in_point    = (cur_state == ST_POINT);
  assign win_reached = (score1 == 4'(WIN_SCORE)) || (score2 == 4'(WIN_SCORE));
  assign state       = cur_state;

  // The timers sit at zero outside their own state, so every entry starts a fresh count
  frame_timer #(.LIMIT(SERVE_FRAMES), .W(TMR_W)) u_serve_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (~in_serve),
    .tick  (refr_tick & in_serve),
    .done  (serve_done)
  );

  frame_timer #(.LIMIT(POINT_FRAMES), .W(TMR_W)) u_point_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (~in_point),
    .tick  (refr_tick & in_point),
    .done  (point_done)
  );

  // Start button edge detector; resets high so a button held through reset is not a press
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q <= 1'b1;
    end else begin
      start_q <= start;
    end
  end

  // Match FSM with scores and outputs registered alongside the state they belong to
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= ST_IDLE;
      score1    <= 4'd0;
      score2    <= 4'd0;
      serve_dir <= P1;
      winner    <= P1;
      ball_rst  <= 1'b1;
      move_en   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      case (cur_state)
        ST_IDLE: begin
          if (start_pulse) begin
            score1    <= 4'd0;
            score2    <= 4'd0;
            cur_state <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          if (serve_done) begin
            cur_state <= ST_PLAY;
            ball_rst  <= 1'b0;
            move_en   <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (miss1 || miss2) begin
            cur_state <= ST_POINT;
            ball_rst  <= 1'b1;
            move_en   <= 1'b0;
            if (miss2 && !miss1) begin
              score1    <= score1 + 4'd1;
              serve_dir <= P2;
            end else if (miss1 && !miss2) begin
              score2    <= score2 + 4'd1;
              serve_dir <= P1;
            end
          end
        end
        ST_POINT: begin
          if (point_done) begin
            if (win_reached) begin
              winner    <= (score2 == 4'(WIN_SCORE)) ? P2 : P1;
              game_over <= 1'b1;
              cur_state <= ST_OVER;
            end else begin
              cur_state <= ST_SERVE;
            end
          end
        end
        ST_OVER: begin
          if (start_pulse) begin
            score1    <= 4'd0;
            score2    <= 4'd0;
            serve_dir <= ~winner;
            game_over <= 1'b0;
            cur_state <= ST_SERVE;
          end
        end
        default: begin
          cur_state <= ST_IDLE;
          ball_rst  <= 1'b1;
          move_en   <= 1'b0;
          game_over <= 1'b0;
        end
      endcase
    end
  end

endmodule
